regfile_dump: RTL and testbench

Sequential read-out engine for the 32x32 MIPS register file. On a start pulse it requests a processor freeze, then walks a register index range through one register-file read port. Each word is presented on a valid/ready stream for the debug/trace path. It is the reader counterpart to the register-file write port and sits beside the multi-cycle datapath, sharing the `rs` read port while the core is halted.

---
 rtl/regfile_dump.sv | 189 ++++++++++++++++++
 tb/tb_regfile_dump.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// Sequential read-out engine for the 32x32 register file: freezes the core,
// walks an index range through the rs read port and streams each word out.
module regfile_dump #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] first,
   input  logic [ADDR_W-1:0] last,
   input  logic              abort,
   output logic              halt_req,
   input  logic              halt_ack,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_idx,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HALT = 3'd1,
      READ = 3'd2,
      SEND = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   idx_reg, idx_next;
   logic [ADDR_W-1:0]   lst_reg, lst_next;
   logic [ADDR_W-1:0]   rd_addr_reg, rd_addr_next;
   logic [DATA_W-1:0]   out_data_reg, out_data_next;
   logic [ADDR_W-1:0]   out_idx_reg, out_idx_next;
   logic                out_last_reg, out_last_next;
   logic                out_valid_reg, out_valid_next;
   logic                halt_req_reg, halt_req_next;
   logic                busy_reg, busy_next;
   logic                done_reg, done_next;
   logic                err_reg, err_next;

   logic                handshake;
   logic [ADDR_W-1:0]   idx_inc;

   assign handshake = out_valid_reg && out_ready;
   assign idx_inc   = idx_reg + ADDR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         lst_reg       <= '0;
         rd_addr_reg   <= '0;
         out_data_reg  <= '0;
         out_idx_reg   <= '0;
         out_last_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         halt_req_reg  <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         lst_reg       <= lst_next;
         rd_addr_reg   <= rd_addr_next;
         out_data_reg  <= out_data_next;
         out_idx_reg   <= out_idx_next;
         out_last_reg  <= out_last_next;
         out_valid_reg <= out_valid_next;
         halt_req_reg  <= halt_req_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         err_reg       <= err_next;
      end
   end

   // Every output is computed one state ahead so it comes straight from a flop.
   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      lst_next       = lst_reg;
      rd_addr_next   = '0;
      out_data_next  = out_data_reg;
      out_idx_next   = out_idx_reg;
      out_last_next  = out_last_reg;
      out_valid_next = out_valid_reg;
      halt_req_next  = halt_req_reg;
      done_next      = 1'b0;
      err_next       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (start) begin
               if (first <= last) begin
                  state_next    = HALT;
                  idx_next      = first;
                  lst_next      = last;
                  halt_req_next = 1'b1;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         HALT: begin
            if (halt_ack) begin
               state_next   = READ;
               rd_addr_next = idx_reg;
            end
         end
         READ: begin
            state_next     = SEND;
            out_data_next  = rd_data;
            out_idx_next   = idx_reg;
            out_last_next  = (idx_reg == lst_reg);
            out_valid_next = 1'b1;
         end
         SEND: begin
            if (handshake) begin
               out_valid_next = 1'b0;
               if (out_last_reg) begin
                  state_next    = DONE;
                  halt_req_next = 1'b0;
                  done_next     = 1'b1;
               end else begin
                  state_next   = READ;
                  idx_next     = idx_inc;
                  rd_addr_next = idx_inc;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
            halt_req_next  = 1'b0;
         end
      endcase

      // Abort beats any handshake completing in the same cycle.
      if (abort && (state_reg != IDLE)) begin
         state_next     = IDLE;
         rd_addr_next   = '0;
         out_valid_next = 1'b0;
         halt_req_next  = 1'b0;
         done_next      = 1'b0;
      end

      busy_next = (state_next != IDLE);
   end

   assign halt_req  = halt_req_reg;
   assign rd_addr   = rd_addr_reg;
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_idx   = out_idx_reg;
   assign out_last  = out_last_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign err       = err_reg;

`ifndef SYNTHESIS
   a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready && !abort) |=>
         (out_valid && $stable(out_data) && $stable(out_idx) && $stable(out_last)));

   a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
      done |=> !done);

   a_rd_addr_quiet: assert property (@(posedge clk) disable iff (!rst_n)
      (state_reg != READ) |-> (rd_addr == '0));

   a_valid_in_send: assert property (@(posedge clk) disable iff (!rst_n)
      out_valid == (state_reg == SEND));

   a_idx_in_range: assert property (@(posedge clk) disable iff (!rst_n)
      (state_reg != IDLE) |-> ((idx_reg <= lst_reg) && (int'(lst_reg) < NUM_REGS)));
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: table of dump vectors plus hand-written
// abort, reset and idle-input sequences against a behavioural register file.
module tb_regfile_dump;

   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] first = '0;
   logic [ADDR_W-1:0] last = '0;
   logic              abort = 1'b0;
   logic              halt_ack = 1'b0;
   logic              out_ready = 1'b0;
   logic              halt_req, out_valid, out_last, busy, done, err;
   logic [ADDR_W-1:0] rd_addr, out_idx;
   logic [DATA_W-1:0] rd_data, out_data;

   logic [DATA_W-1:0] regs [NUM_REGS];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign rd_data = regs[rd_addr];

   regfile_dump #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .first(first), .last(last),
      .abort(abort), .halt_req(halt_req), .halt_ack(halt_ack), .rd_addr(rd_addr),
      .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
      .busy(busy), .done(done), .err(err)
   );

   typedef struct {
      logic [ADDR_W-1:0] first;
      logic [ADDR_W-1:0] last;
      int                ack_delay;
      bit                rand_ready;
      bit                scramble;
      bit                repulse;
      bit                exp_err;
      int                exp_words;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_val(input int i, input bit scr);
      return scr ? ((32'(i) * 32'h0101_0101) ^ 32'hDEAD_0000) : 32'(i);
   endfunction

   task automatic fill_regs(input bit scr);
      for (int i = 0; i < NUM_REGS; i++) regs[i] = exp_val(i, scr);
   endtask

   task automatic run_vec(input vec_t v);
      int nwords = 0;
      int ndone = 0;
      int cyc = 0;
      int first_valid_cyc = -1;
      int done_cyc = -1;
      logic [ADDR_W-1:0] exp_idx;
      bit stalled = 1'b0;
      logic [DATA_W-1:0] held_data = '0;
      logic [ADDR_W-1:0] held_idx = '0;

      fill_regs(v.scramble);
      @(negedge clk);
      first = v.first; last = v.last; start = 1'b1;
      halt_ack = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      if (v.exp_err) begin
         check("err_pulse", err, 1);
         check("err_busy", busy, 0);
         check("err_halt_req", halt_req, 0);
         @(negedge clk);
         check("err_one_cycle", err, 0);
         check("err_busy_after", busy, 0);
         check("err_halt_after", halt_req, 0);
         $display("vector first=%0d last=%0d: start rejected", v.first, v.last);
         return;
      end
      check("start_to_halt_req", halt_req, 1);
      check("busy_after_start", busy, 1);
      check("no_err_on_start", err, 0);
      for (int i = 0; i < v.ack_delay; i++) begin
         check("ackwait_rd_addr", rd_addr, 0);
         check("ackwait_out_valid", out_valid, 0);
         check("ackwait_halt_req", halt_req, 1);
         @(negedge clk);
      end
      halt_ack = 1'b1;
      exp_idx = v.first;
      while (cyc < 400 && ndone == 0) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (cyc == 1) check("read_rd_addr", rd_addr, 32'(v.first));
         if (stalled) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, held_data);
            check("stall_idx", out_idx, held_idx);
         end
         out_ready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled = 1'b0;
         if (out_valid) begin
            check("send_rd_addr", rd_addr, 0);
            if (first_valid_cyc < 0) begin
               first_valid_cyc = cyc;
               if (v.repulse) begin
                  first = '0; last = 5'd31; start = 1'b1;
               end
            end
            if (out_ready) begin
               check("word_idx", out_idx, 32'(exp_idx));
               check("word_data", out_data, exp_val(int'(exp_idx), v.scramble));
               check("word_last", out_last, 32'(exp_idx == v.last));
               $display("word idx=%0d data=0x%08h last=%0d", out_idx, out_data, out_last);
               nwords++;
               exp_idx = exp_idx + ADDR_W'(1);
            end else begin
               stalled = 1'b1;
               held_data = out_data;
               held_idx = out_idx;
            end
         end
         if (done) begin
            ndone++;
            done_cyc = cyc;
            check("done_halt_req", halt_req, 0);
            check("done_busy", busy, 1);
         end
      end
      start = 1'b0;
      check("word_count", nwords, v.exp_words);
      check("done_seen", ndone, 1);
      check("first_valid_latency", first_valid_cyc, 2);
      if (!v.rand_ready) check("read_to_done_cycles", done_cyc - first_valid_cyc, 2 * v.exp_words - 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
      halt_ack = 1'b0;
      out_ready = 1'b0;
      $display("vector first=%0d last=%0d: %0d words, done after %0d cycles", v.first, v.last, nwords, done_cyc);
   endtask

   initial begin
      int wait_cyc;
      int done_cnt;

      vecs[0] = '{5'd0,  5'd31, 0,  1'b0, 1'b0, 1'b0, 1'b0, 32};
      vecs[1] = '{5'd5,  5'd7,  0,  1'b1, 1'b1, 1'b0, 1'b0, 3};
      vecs[2] = '{5'd2,  5'd4,  10, 1'b0, 1'b1, 1'b0, 1'b0, 3};
      vecs[3] = '{5'd9,  5'd3,  0,  1'b0, 1'b0, 1'b0, 1'b1, 0};
      vecs[4] = '{5'd31, 5'd31, 0,  1'b0, 1'b1, 1'b0, 1'b0, 1};
      vecs[5] = '{5'd0,  5'd0,  0,  1'b0, 1'b1, 1'b0, 1'b0, 1};
      vecs[6] = '{5'd3,  5'd6,  0,  1'b0, 1'b1, 1'b1, 1'b0, 4};
      vecs[7] = '{5'd10, 5'd12, 3,  1'b1, 1'b1, 1'b0, 1'b0, 3};
      fill_regs(1'b0);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_halt_req", halt_req, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_out_last", out_last, 0);
      rst_n = 1'b1;
      $display("reset released");

      // Abort while idle has no effect
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("idle_abort_busy", busy, 0);
      check("idle_abort_halt", halt_req, 0);
      check("idle_abort_err", err, 0);
      check("idle_abort_done", done, 0);
      $display("abort in idle applied");

      foreach (vecs[k]) run_vec(vecs[k]);

      // Abort while SEND is stalled
      fill_regs(1'b1);
      @(negedge clk);
      first = 5'd3; last = 5'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0; halt_ack = 1'b1; out_ready = 1'b0;
      wait_cyc = 0;
      while (!out_valid && wait_cyc < 10) begin
         @(negedge clk);
         wait_cyc++;
      end
      check("abort_reached_send", out_valid, 1);
      check("abort_send_idx", out_idx, 3);
      @(negedge clk);
      check("abort_still_stalled", out_valid, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_out_valid", out_valid, 0);
      check("abort_halt_req", halt_req, 0);
      check("abort_busy", busy, 0);
      done_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (done) done_cnt++;
         @(negedge clk);
      end
      check("abort_no_done", done_cnt, 0);
      check("abort_stays_idle", busy, 0);
      halt_ack = 1'b0;
      $display("abort during stalled send applied");

      // Asynchronous reset during READ
      @(negedge clk);
      first = 5'd8; last = 5'd12; start = 1'b1;
      @(negedge clk);
      start = 1'b0; halt_ack = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check("pre_reset_rd_addr", rd_addr, 8);
      check("pre_reset_out_data_nonzero", 32'(out_data != '0), 1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_halt_req", halt_req, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_rd_addr", rd_addr, 0);
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_out_data", out_data, 0);
      check("async_rst_out_idx", out_idx, 0);
      check("async_rst_out_last", out_last, 0);
      @(negedge clk);
      rst_n = 1'b1;
      halt_ack = 1'b0;
      @(negedge clk);
      check("post_reset_busy", busy, 0);
      check("post_reset_out_valid", out_valid, 0);
      $display("reset during read applied");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
